// File: rtl/rob_multi_pkg.sv
// Shared types for the multi-retire reorder buffer: per-entry state and the
// per-slot commit payload handed to the RRF/free list.
package rob_multi_pkg;

  localparam int unsigned PHYS_REG_W = 6;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  mispredict;
    logic [31:0]           target;
    logic [PHYS_REG_W-1:0] pd;
    logic [4:0]            rd;
    logic                  regf_we;
    logic [31:0]           pc;
  } rob_mp_entry_t;

  typedef struct packed {
    logic [PHYS_REG_W-1:0] pd;
    logic [4:0]            rd;
    logic                  regf_we;
    logic [31:0]           pc;
  } commit_slot_t;

endpackage

// File: rtl/rob_commit_select.sv
// Retire selection over the head window: contiguous done entries from slot 0,
// with a mispredicted entry closing the group and raising flush.
module rob_commit_select
  import rob_multi_pkg::*;
#(
  parameter  int unsigned COMMIT_WIDTH = 2,
  localparam int unsigned CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  rob_mp_entry_t [COMMIT_WIDTH-1:0] win_i,
  output logic          [COMMIT_WIDTH-1:0] commit_valid_o,
  output commit_slot_t  [COMMIT_WIDTH-1:0] slot_o,
  output logic          [CNT_W-1:0]        retire_cnt_o,
  output logic                             flush_o,
  output logic          [31:0]             flush_pc_o
);

  logic chain;

  always_comb begin
    commit_valid_o = '0;
    slot_o         = '0;
    retire_cnt_o   = '0;
    flush_o        = 1'b0;
    flush_pc_o     = '0;
    chain          = 1'b1;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (chain && win_i[k].valid && win_i[k].done) begin
        commit_valid_o[k] = 1'b1;
        slot_o[k]         = '{pd: win_i[k].pd, rd: win_i[k].rd,
                              regf_we: win_i[k].regf_we, pc: win_i[k].pc};
        retire_cnt_o      = CNT_W'(k + 1);
        if (win_i[k].mispredict) begin
          flush_o    = 1'b1;
          flush_pc_o = win_i[k].target;
          chain      = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer with NUM_CDB completion ports, up to COMMIT_WIDTH in-order
// retires per cycle and commit-time mispredict flush.
module rob_multi
  import rob_multi_pkg::*;
#(
  parameter  int unsigned DEPTH        = 64,
  parameter  int unsigned NUM_CDB      = 4,
  parameter  int unsigned COMMIT_WIDTH = 2,
  parameter  int unsigned PREG_W       = PHYS_REG_W,
  localparam int unsigned IDX_W        = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enq_valid,
  input  logic [PREG_W-1:0]                   enq_pd,
  input  logic [4:0]                          enq_rd,
  input  logic                                enq_regf_we,
  input  logic [31:0]                         enq_pc,
  output logic                                enq_ready,
  output logic [IDX_W-1:0]                    enq_idx,
  input  logic [NUM_CDB-1:0]                  cdb_valid,
  input  logic [NUM_CDB-1:0][IDX_W-1:0]       cdb_idx,
  input  logic [NUM_CDB-1:0]                  cdb_mispredict,
  input  logic [NUM_CDB-1:0][31:0]            cdb_target,
  output logic [COMMIT_WIDTH-1:0]             commit_valid,
  output logic [COMMIT_WIDTH-1:0][PREG_W-1:0] commit_pd,
  output logic [COMMIT_WIDTH-1:0][4:0]        commit_rd,
  output logic [COMMIT_WIDTH-1:0]             commit_regf_we,
  output logic [COMMIT_WIDTH-1:0][31:0]       commit_pc,
  output logic                                flush,
  output logic [31:0]                         flush_pc,
  output logic [IDX_W:0]                      count
);

  localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1);

  rob_mp_entry_t                     rob_q [DEPTH];
  logic          [IDX_W:0]           head_q, head_d, tail_q, tail_d;
  logic          [IDX_W-1:0]         win_idx [COMMIT_WIDTH];
  rob_mp_entry_t [COMMIT_WIDTH-1:0]  win;
  commit_slot_t  [COMMIT_WIDTH-1:0]  slots;
  logic          [CNT_W-1:0]         ret_cnt;
  logic                              full, enq_fire;

  assign full      = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign enq_ready = !full;
  assign enq_idx   = tail_q[IDX_W-1:0];
  assign count     = tail_q - head_q;
  assign enq_fire  = enq_valid && enq_ready && !flush;

  always_comb begin
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      win_idx[k] = head_q[IDX_W-1:0] + IDX_W'(k);
      win[k]     = rob_q[win_idx[k]];
    end
  end

  rob_commit_select #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_sel (
    .win_i          (win),
    .commit_valid_o (commit_valid),
    .slot_o         (slots),
    .retire_cnt_o   (ret_cnt),
    .flush_o        (flush),
    .flush_pc_o     (flush_pc)
  );

  always_comb begin
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      commit_pd[k]      = PREG_W'(slots[k].pd);
      commit_rd[k]      = slots[k].rd;
      commit_regf_we[k] = slots[k].regf_we;
      commit_pc[k]      = slots[k].pc;
    end
  end

  // A flush collapses the buffer to empty just past the mispredicted entry.
  always_comb begin
    head_d = head_q + (IDX_W+1)'(ret_cnt);
    tail_d = flush ? head_d : tail_q + (IDX_W+1)'(enq_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) rob_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++)
        if (commit_valid[k]) rob_q[win_idx[k]].valid <= 1'b0;
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) rob_q[i].valid <= 1'b0;
      end else begin
        for (int unsigned c = 0; c < NUM_CDB; c++) begin
          if (cdb_valid[c] && rob_q[cdb_idx[c]].valid) begin
            rob_q[cdb_idx[c]].done       <= 1'b1;
            rob_q[cdb_idx[c]].mispredict <= cdb_mispredict[c];
            rob_q[cdb_idx[c]].target     <= cdb_target[c];
          end
        end
        if (enq_fire)
          rob_q[tail_q[IDX_W-1:0]] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                        target: '0, pd: PHYS_REG_W'(enq_pd),
                                        rd: enq_rd, regf_we: enq_regf_we, pc: enq_pc};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned a = 0; a < NUM_CDB; a++)
        for (int unsigned b = a + 1; b < NUM_CDB; b++)
          a_cdb_unique: assert (!(cdb_valid[a] && cdb_valid[b] && cdb_idx[a] == cdb_idx[b]));
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Scoreboard bench for rob_multi: an in-order queue model predicts retires,
// flushes and occupancy; a negedge monitor compares against the DUT.
module tb_rob_multi;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NC    = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned PW    = 6;
  localparam int unsigned IW    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     enq_valid;
  logic [PW-1:0]            enq_pd;
  logic [4:0]               enq_rd;
  logic                     enq_regf_we;
  logic [31:0]              enq_pc;
  logic                     enq_ready;
  logic [IW-1:0]            enq_idx;
  logic [NC-1:0]            cdb_valid;
  logic [NC-1:0][IW-1:0]    cdb_idx;
  logic [NC-1:0]            cdb_mispredict;
  logic [NC-1:0][31:0]      cdb_target;
  logic [CW-1:0]            commit_valid;
  logic [CW-1:0][PW-1:0]    commit_pd;
  logic [CW-1:0][4:0]       commit_rd;
  logic [CW-1:0]            commit_regf_we;
  logic [CW-1:0][31:0]      commit_pc;
  logic                     flush;
  logic [31:0]              flush_pc;
  logic [IW:0]              count;

  rob_multi #(.DEPTH(DEPTH), .NUM_CDB(NC), .COMMIT_WIDTH(CW), .PREG_W(PW)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_pd(enq_pd), .enq_rd(enq_rd),
    .enq_regf_we(enq_regf_we), .enq_pc(enq_pc),
    .enq_ready(enq_ready), .enq_idx(enq_idx),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .commit_valid(commit_valid), .commit_pd(commit_pd), .commit_rd(commit_rd),
    .commit_regf_we(commit_regf_we), .commit_pc(commit_pc),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  typedef struct {
    int unsigned   idx;
    logic [31:0]   pc;
    logic [PW-1:0] pd;
    logic [4:0]    rd;
    logic          we;
    bit            done;
    bit            mp;
    logic [31:0]   tgt;
  } ment_t;

  typedef logic [32+PW+5+1-1:0] slot_t;

  ment_t       mq[$];
  slot_t       expq[$];
  int unsigned mhead;
  bit          armed = 1'b0;
  logic [CW-1:0] exp_mask;
  bit          exp_flush;
  logic [31:0] exp_fpc;
  int unsigned exp_count;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // In-order group rule: oldest done entries, stopping after a mispredict.
  function automatic void calc_group(output int unsigned r, output bit f);
    r = 0;
    f = 1'b0;
    for (int unsigned k = 0; k < CW && k < mq.size(); k++) begin
      if (!mq[k].done) break;
      r++;
      if (mq[k].mp) begin
        f = 1'b1;
        break;
      end
    end
  endfunction

  always @(posedge clk) begin : model
    int unsigned r, pre;
    bit f;
    if (rst) begin
      mq.delete();
      mhead = 0;
      armed = 1'b1;
    end else if (armed) begin
      calc_group(r, f);
      pre = mq.size();
      for (int unsigned k = 0; k < r; k++) void'(mq.pop_front());
      if (f) mq.delete();
      else begin
        for (int unsigned c = 0; c < NC; c++)
          if (cdb_valid[c])
            foreach (mq[j])
              if (mq[j].idx == cdb_idx[c]) begin
                mq[j].done = 1'b1;
                mq[j].mp   = cdb_mispredict[c];
                mq[j].tgt  = cdb_target[c];
              end
        if (enq_valid && pre < DEPTH)
          mq.push_back('{idx: (mhead + pre) % DEPTH, pc: enq_pc, pd: enq_pd, rd: enq_rd,
                         we: enq_regf_we, done: 1'b0, mp: 1'b0, tgt: 32'h0});
      end
      mhead = (mhead + r) % (2 * DEPTH);
    end
    if (armed) begin
      calc_group(r, f);
      exp_mask = '0;
      for (int unsigned k = 0; k < r; k++) begin
        exp_mask[k] = 1'b1;
        expq.push_back({mq[k].pc, mq[k].pd, mq[k].rd, mq[k].we});
      end
      exp_flush = f;
      exp_fpc   = f ? mq[r-1].tgt : 32'h0;
      exp_count = mq.size();
    end
  end

  always @(negedge clk) begin : monitor
    slot_t e;
    if (armed) begin
      chk("commit_valid", 64'(commit_valid), 64'(exp_mask));
      for (int unsigned k = 0; k < CW; k++) begin
        if (commit_valid[k]) begin
          if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_retire: slot %0d pc %0h, none expected", k, commit_pc[k]);
          end else begin
            e = expq.pop_front();
            chk("retire_slot", 64'({commit_pc[k], commit_pd[k], commit_rd[k], commit_regf_we[k]}), 64'(e));
          end
        end
      end
      expq.delete();
      chk("flush", 64'(flush), 64'(exp_flush));
      if (exp_flush || flush) chk("flush_pc", 64'(flush_pc), 64'(exp_fpc));
      chk("count", 64'(count), 64'(exp_count));
      chk("enq_ready", 64'(enq_ready), 64'(exp_count < DEPTH));
      chk("enq_idx", 64'(enq_idx), 64'((mhead + exp_count) % DEPTH));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    enq_valid      = 1'b0;
    enq_pd         = '0;
    enq_rd         = '0;
    enq_regf_we    = 1'b0;
    enq_pc         = '0;
    cdb_valid      = '0;
    cdb_idx        = '0;
    cdb_mispredict = '0;
    cdb_target     = '0;
  endtask

  task automatic enq_rand();
    enq_valid   = 1'b1;
    enq_pc      = $urandom;
    enq_pd      = PW'($urandom);
    enq_rd      = 5'($urandom);
    enq_regf_we = 1'($urandom);
  endtask

  task automatic cdb(input int unsigned ch, input int unsigned idx, input bit mp, input logic [31:0] tgt);
    cdb_valid[ch]      = 1'b1;
    cdb_idx[ch]        = IW'(idx);
    cdb_mispredict[ch] = mp;
    cdb_target[ch]     = tgt;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Completes random not-yet-done entries; occasionally pokes the empty tail slot.
  task automatic rand_cdb(input int unsigned pct, input bit mp_en);
    int unsigned cand[$];
    int unsigned j;
    bit tail_used = 1'b0;
    cdb_valid = '0;
    cdb_mispredict = '0;
    foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].idx);
    for (int unsigned c = 0; c < NC; c++) begin
      if ($urandom_range(99) < pct && cand.size() > 0) begin
        j = $urandom_range(cand.size() - 1);
        cdb(c, cand[j], mp_en && ($urandom_range(15) == 0), $urandom);
        cand.delete(j);
      end else if ($urandom_range(9) == 0 && !tail_used && mq.size() < DEPTH) begin
        cdb(c, (mhead + mq.size()) % DEPTH, 1'b0, $urandom);
        tail_used = 1'b1;
      end
    end
  endtask

  task automatic drain(input int unsigned budget, input bit mp_en);
    for (int unsigned i = 0; i < budget && mq.size() != 0; i++) begin
      enq_valid = 1'b0;
      rand_cdb(100, mp_en);
      step();
    end
    idle();
    step();
    vectors++;
    if (mq.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d entries left, required 0", mq.size());
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Fill with no completions.
    for (int i = 0; i < 66; i++) begin enq_rand(); step(); end
    idle();
    chk("fill_count", 64'(count), 64'd64);
    chk("fill_ready", 64'(enq_ready), 64'd0);
    chk("fill_commit", 64'(commit_valid), 64'd0);

    // Out-of-order completion in a single cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin enq_rand(); step(); end
    idle();
    for (int unsigned c = 0; c < 4; c++) cdb(c, 3 - c, 1'b0, 32'h0);
    step();
    idle();
    chk("ooo_pair0", 64'(commit_valid), 64'd3);
    step();
    chk("ooo_pair1", 64'(commit_valid), 64'd3);
    step();
    chk("ooo_empty", 64'(count), 64'd0);

    // Younger completes first; head completes three cycles later.
    do_reset();
    for (int i = 0; i < 2; i++) begin enq_rand(); step(); end
    idle();
    cdb(0, 1, 1'b0, 32'h0);
    step();
    idle();
    step();
    step();
    chk("blocked_head", 64'(commit_valid), 64'd0);
    cdb(0, 0, 1'b0, 32'h0);
    step();
    idle();
    chk("late_head", 64'(commit_valid), 64'd3);
    step();

    // Mispredict closes the group and flushes.
    do_reset();
    for (int i = 0; i < 5; i++) begin enq_rand(); step(); end
    idle();
    cdb(0, 0, 1'b0, 32'h0);
    cdb(1, 1, 1'b1, 32'h8000_0040);
    cdb(2, 2, 1'b0, 32'h0);
    step();
    idle();
    chk("mp_commit", 64'(commit_valid), 64'd3);
    chk("mp_flush", 64'(flush), 64'd1);
    chk("mp_flush_pc", 64'(flush_pc), 64'h8000_0040);
    step();
    chk("mp_count", 64'(count), 64'd0);
    chk("mp_tail", 64'(enq_idx), 64'd2);
    chk("mp_flush_once", 64'(flush), 64'd0);
    step();

    // Retire window straddling the top of the index space.
    do_reset();
    for (int i = 0; i < 62; i++) begin enq_rand(); step(); end
    idle();
    drain(200, 1'b0);
    chk("wrap_tail", 64'(enq_idx), 64'd62);
    for (int i = 0; i < 4; i++) begin enq_rand(); step(); end
    idle();
    cdb(0, 62, 1'b0, 32'h0);
    cdb(1, 63, 1'b0, 32'h0);
    cdb(2, 0, 1'b0, 32'h0);
    cdb(3, 1, 1'b0, 32'h0);
    step();
    idle();
    chk("wrap_pair0", 64'(commit_valid), 64'd3);
    step();
    chk("wrap_pair1", 64'(commit_valid), 64'd3);
    step();
    chk("wrap_count", 64'(count), 64'd0);
    chk("wrap_tail2", 64'(enq_idx), 64'd2);

    // Full buffer: no same-cycle credit from retirement.
    do_reset();
    for (int i = 0; i < 64; i++) begin enq_rand(); step(); end
    enq_rand();
    cdb(0, 0, 1'b0, 32'h0);
    step();
    cdb_valid = '0;
    chk("full_head_commit", 64'(commit_valid), 64'd1);
    chk("full_no_credit", 64'(enq_ready), 64'd0);
    enq_rand();
    step();
    chk("freed_ready", 64'(enq_ready), 64'd1);
    chk("freed_idx", 64'(enq_idx), 64'd0);
    chk("freed_count", 64'(count), 64'd63);
    enq_rand();
    step();
    chk("refill_count", 64'(count), 64'd64);
    enq_rand();
    cdb(0, 1, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_commit", 64'(commit_valid), 64'd0);

    // Randomised traffic with occasional resets and mispredicts.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(599) == 0);
      if ($urandom_range(9) < 7) enq_rand(); else enq_valid = 1'b0;
      rand_cdb(50, 1'b1);
      step();
    end
    rst = 1'b0;
    drain(400, 1'b1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised reorder buffer; successor to the single-retire ROB.
- Sits between rename/dispatch, the N functional-unit CDB broadcast ports, and the RRF/free list.
- Accepts one dispatched instruction per cycle, marks entries done from NUM_CDB independent CDB channels, and retires up to COMMIT_WIDTH entries per cycle in program order.
- Owns branch-mispredict recovery: commit-time flush with a redirect PC.

Parameters:
DEPTH, 64, number of entries; power of two, >= 4.
NUM_CDB, 4, number of completion (CDB) channels.
COMMIT_WIDTH, 2, maximum retires per cycle; 1..4, <= DEPTH.
PREG_W, 6, physical register tag width.
IDX_W, $clog2(DEPTH), entry index width (derived, localparam).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
enq_valid  in  1  dispatch request.
enq_pd  in  PREG_W  physical destination.
enq_rd  in  5  architectural destination.
enq_regf_we  in  1  instruction writes rd.
enq_pc  in  32  instruction PC.
enq_ready  out  1  entry available; enqueue happens iff enq_valid & enq_ready.
enq_idx  out  IDX_W  index the next enqueue will occupy (tail slot).
cdb_valid  in  NUM_CDB  per-channel completion.
cdb_idx  in  NUM_CDB x IDX_W  per-channel entry index.
cdb_mispredict  in  NUM_CDB  channel reports a mispredicted control transfer.
cdb_target  in  NUM_CDB x 32  correct next PC when mispredict.
commit_valid  out  COMMIT_WIDTH  slot k retires this cycle; slots are contiguous from slot 0.
commit_pd  out  COMMIT_WIDTH x PREG_W  retiring physical destination.
commit_rd  out  COMMIT_WIDTH x 5  retiring architectural destination.
commit_regf_we  out  COMMIT_WIDTH  retiring write-enable.
commit_pc  out  COMMIT_WIDTH x 32  retiring PC.
flush  out  1  mispredict recovery pulse.
flush_pc  out  32  redirect PC, valid when flush.
count  out  IDX_W+1  occupied entries.

Behaviour:
- State: head and tail pointers of IDX_W+1 bits each (wrap bit). Per-entry valid, done, mispredict, target, pd, rd, regf_we, pc.
- Reset: head = tail = 0. All valid/done cleared. Every output is 0 during and after reset, except enq_ready = 1.
- full = index bits equal and wrap bits differ. empty = head == tail. count = tail - head.
- enq_ready = !full, computed from registered state only. There is no same-cycle credit from retirement.
- Enqueue writes slot tail[IDX_W-1:0] with valid = 1, done = 0, mispredict = 0, then sets tail += 1. enq_idx = tail[IDX_W-1:0].
- CDB: for each channel with cdb_valid, the entry's done is set (and mispredict/target latched) at the clock edge.
  - An entry becomes retirable one cycle after its CDB write; there is no CDB-to-commit bypass.
  - A CDB write to an invalid entry is ignored.
  - Two channels naming the same index in one cycle is illegal; guard with an assertion.
- Retire selection is combinational from registered state:
  - Slot k is valid iff entries head+0..head+k are all valid & done, and none of head+0..head+k-1 is mispredicted.
  - A mispredicted entry therefore retires as the last slot of its group.
  - head advances by the number of retired entries, modulo 2*DEPTH via the wrap bit.
- Flush: if the last retiring slot is mispredicted, flush = 1 and flush_pc = its target in the same cycle.
  - At that edge, all valid bits clear, head = tail = head + retired_count, and any concurrent enqueue is dropped.
  - In that cycle, CDB writes are discarded.
  - flush is high for exactly one cycle.
- Simultaneous enqueue + retire in a non-flush cycle: both take effect. count updates by +1 - retired.
- Full with pending retire: enq_ready stays 0 that cycle; the enqueue is accepted the next cycle.
- Wrap-around: the retire window may straddle index DEPTH-1 -> 0. Indices are taken modulo DEPTH.
- rst asserted mid-operation overrides everything, including a same-cycle flush and enqueue.

Decomposition:
- rv32i_types gains rob_mp_entry_t (valid, done, mispredict, target, pd, rd, regf_we, pc) and commit_slot_t (pd, rd, regf_we, pc).
- PREG_W default comes from the existing physical register constant.
- One sub-module: rob_commit_select. Purely combinational; takes COMMIT_WIDTH window entries and produces commit_valid plus retire count and the flush condition.

Test Plan:
- Reset, then enqueue 64 entries with no completions -> enq_ready falls after the 64th, count = 64, no commit_valid.
- Enqueue idx 0..3; CDB channels 0..3 complete 3,2,1,0 in one cycle -> next cycle commit_valid = 2'b11 (idx 0,1), following cycle idx 2,3; count returns to 0.
- Complete idx 1 only, then idx 0 three cycles later -> no retire until the cycle after idx 0 is marked, then both retire together.
- Enqueue 5; idx 0 done, idx 1 done with mispredict, target 32'h8000_0040; idx 2 done -> one cycle with commit_valid = 2'b11, flush = 1, flush_pc = 32'h8000_0040. Next cycle count = 0, head = tail = 2, idx 2 never retires.
- Pre-fill so head = 62; enqueue 4 (idx 62,63,0,1), complete all -> retires 62,63 then 0,1; pointer wrap bit toggles; count = 0.
- Full ROB, head done, enq_valid held high -> commit of the head in cycle T, enqueue accepted at T+1 at the freed slot. Assert rst mid-stream -> count = 0 and commit_valid = 0 the next cycle.
